// File: rtl/axi_rd_slave_mem_if.sv
// AXI4 read-address / read-data channel bundle shared by axi_rd_slave_mem and its masters.
interface axi_rd_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  s_axi_arid;
    logic [ADDR_WIDTH-1:0] s_axi_araddr;
    logic [7:0]            s_axi_arlen;
    logic [2:0]            s_axi_arsize;
    logic [1:0]            s_axi_arburst;
    logic                  s_axi_arvalid;
    logic                  s_axi_arready;
    logic                  s_axi_rid;
    logic [DATA_WIDTH-1:0] s_axi_rdata;
    logic [1:0]            s_axi_rresp;
    logic                  s_axi_rlast;
    logic                  s_axi_rvalid;
    logic                  s_axi_rready;

    modport slave (
        input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
        input  s_axi_arvalid, s_axi_rready,
        output s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
    );

    modport master (
        output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
        output s_axi_arvalid, s_axi_rready,
        input  s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
    );
endinterface

// File: rtl/axi_rd_slave_mem.sv
// AXI4 read responder over an internal RAM with a backdoor write port.
// Optional AXI_RD_SLV_BSWAP_EN: byte-reverse rdata on OKAY beats.
module axi_rd_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         s_axi_aclk,
    input  logic                         s_axi_aresetn,
    axi_rd_slave_mem_if.slave            axi,
    input  logic                         mem_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_wr_addr,
    input  logic [DATA_WIDTH-1:0]        mem_wr_data,
    output logic                         busy
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int MEM_AW = $clog2(MEM_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic                  arready_q, rvalid_q, rlast_q, rid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, idx_d;
    logic [7:0]            len_q, len_d, cnt_q, cnt_d;
    logic                  fixed_q, fixed_d, slverr_q, slverr_d;
    logic                  ar_hs, r_hs, adv, load;
    logic [1:0]            resp_d;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [1:0] beat_resp(input logic slverr, input logic [ADDR_WIDTH-1:0] idx);
        if (slverr)
            return 2'b10;
        if (idx >= ADDR_WIDTH'(MEM_DEPTH))
            return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [DATA_WIDTH-1:0] word);
`ifdef AXI_RD_SLV_BSWAP_EN
        logic [DATA_WIDTH-1:0] r;
        for (int b = 0; b < BYTES; b++)
            r[8*b +: 8] = word[DATA_WIDTH-8-8*b +: 8];
        return r;
`else
        return word;
`endif
    endfunction

    assign ar_hs = axi.s_axi_arvalid && arready_q;
    assign r_hs  = rvalid_q && axi.s_axi_rready;
    assign adv   = r_hs && !rlast_q;
    assign load  = ar_hs || adv;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_hs) state_d = BURST;
            BURST:   if (r_hs && rlast_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next-beat address/count: the RAM is addressed with the beat about to be presented.
    always_comb begin
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        fixed_d  = fixed_q;
        slverr_d = slverr_q;
        if (ar_hs) begin
            addr_d   = axi.s_axi_araddr;
            len_d    = axi.s_axi_arlen;
            cnt_d    = 8'd0;
            fixed_d  = (axi.s_axi_arburst == 2'b00);
            slverr_d = axi.s_axi_arburst[1] || (axi.s_axi_arsize != 3'(OFF_W));
        end else if (adv) begin
            cnt_d = cnt_q + 8'd1;
            if (!fixed_q)
                addr_d = addr_q + ADDR_WIDTH'(BYTES);
        end
        idx_d  = addr_d >> OFF_W;
        resp_d = beat_resp(slverr_d, idx_d);
    end

    always_ff @(posedge s_axi_aclk) begin
        if (mem_wr_en)
            mem[mem_wr_addr] <= mem_wr_data;
    end

    // Registered R outputs: only reloaded on a new burst or an accepted beat, so stalls hold them.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            addr_q    <= '0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            fixed_q   <= 1'b0;
            slverr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            arready_q <= (state_d == IDLE);
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            fixed_q   <= fixed_d;
            slverr_q  <= slverr_d;
            if (ar_hs)
                rid_q <= axi.s_axi_arid;
            if (load) begin
                rvalid_q <= 1'b1;
                rlast_q  <= (cnt_d == len_d);
                rresp_q  <= resp_d;
                rdata_q  <= (resp_d == 2'b00) ? beat_data(mem[idx_d[MEM_AW-1:0]]) : '0;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    assign axi.s_axi_arready = arready_q;
    assign axi.s_axi_rvalid  = rvalid_q;
    assign axi.s_axi_rlast   = rlast_q;
    assign axi.s_axi_rid     = rid_q;
    assign axi.s_axi_rresp   = rresp_q;
    assign axi.s_axi_rdata   = rdata_q;
    assign busy              = (state_q == BURST);
endmodule
